// File: rtl/mem_port_arbiter_pkg.sv
// Shared types and constants for the IF/DM memory port arbiter.
package mem_port_arbiter_pkg;

    localparam int DEFAULT_ADDR_W = 32;
    localparam int DEFAULT_DATA_W = 32;
    localparam int PERF_CNT_W     = 32;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        IF_WAIT = 2'd1,
        DM_WAIT = 2'd2
    } arb_state_t;

    typedef enum logic {
        GNT_IF = 1'b0,
        GNT_DM = 1'b1
    } grant_t;

endpackage

// File: rtl/mem_port_arbiter_perf_cnt.sv
// Saturating stall-cycle counter; only built when MEM_PORT_ARBITER_PERF_EN is defined.
`ifdef MEM_PORT_ARBITER_PERF_EN
module mem_port_arbiter_perf_cnt
    import mem_port_arbiter_pkg::*;
#(
    parameter int WIDTH = PERF_CNT_W
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             inc_i,
    output logic [WIDTH-1:0] count_o
);

    logic [WIDTH-1:0] count;

    // Count every cycle inc_i is high, sticking at all-ones.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            count <= '0;
        end else if (inc_i && (count != '1)) begin
            count <= count + {{(WIDTH-1){1'b0}}, 1'b1};
        end
    end

    assign count_o = count;

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one variable-latency memory between the fetch
// and data-memory ports of the pipeline. Optional stall counters are enabled
// with the MEM_PORT_ARBITER_PERF_EN macro.
module mem_port_arbiter
    import mem_port_arbiter_pkg::*;
#(
    parameter int ADDR_W = DEFAULT_ADDR_W,
    parameter int DATA_W = DEFAULT_DATA_W
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    input  logic              if_flush_i,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_done_o,
    output logic              if_stall_o,
    input  logic              dm_req_i,
    input  logic              dm_we_i,
    input  logic [ADDR_W-1:0] dm_addr_i,
    input  logic [DATA_W-1:0] dm_wdata_i,
    output logic [DATA_W-1:0] dm_rdata_o,
    output logic              dm_done_o,
    output logic              dm_stall_o,
    output logic              mem_req_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i,
    input  logic              mem_ack_i
`ifdef MEM_PORT_ARBITER_PERF_EN
    ,
    output logic [PERF_CNT_W-1:0] perf_if_stall_o,
    output logic [PERF_CNT_W-1:0] perf_dm_stall_o
`endif
);

    arb_state_t        state, state_next;
    grant_t            last_grant, last_grant_next;
    logic              kill, kill_next, kill_now;
    logic              mem_req_next, mem_we_next;
    logic [ADDR_W-1:0] mem_addr_next;
    logic [DATA_W-1:0] mem_wdata_next;
    logic [DATA_W-1:0] if_rdata_next, dm_rdata_next;
    logic              if_done_next, dm_done_next;
    logic              if_eligible, dm_eligible, grant_dm;

    // A port whose done is pulsing this cycle still shows its old request; it is not a new access yet.
    assign if_eligible = if_req_i & ~if_done_o;
    assign dm_eligible = dm_req_i & ~dm_done_o;
    assign grant_dm    = dm_eligible & (~if_eligible | (last_grant == GNT_IF));

    assign if_stall_o = if_req_i & ~if_done_o;
    assign dm_stall_o = dm_req_i & ~dm_done_o;

    // State, memory-side request and returned-data registers.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state       <= IDLE;
            last_grant  <= GNT_IF;
            kill        <= 1'b0;
            mem_req_o   <= 1'b0;
            mem_we_o    <= 1'b0;
            mem_addr_o  <= '0;
            mem_wdata_o <= '0;
            if_rdata_o  <= '0;
            dm_rdata_o  <= '0;
            if_done_o   <= 1'b0;
            dm_done_o   <= 1'b0;
        end else begin
            state       <= state_next;
            last_grant  <= last_grant_next;
            kill        <= kill_next;
            mem_req_o   <= mem_req_next;
            mem_we_o    <= mem_we_next;
            mem_addr_o  <= mem_addr_next;
            mem_wdata_o <= mem_wdata_next;
            if_rdata_o  <= if_rdata_next;
            dm_rdata_o  <= dm_rdata_next;
            if_done_o   <= if_done_next;
            dm_done_o   <= dm_done_next;
        end
    end

    // Arbitration, access sequencing and completion handling.
    always_comb begin
        state_next      = state;
        last_grant_next = last_grant;
        kill_next       = kill;
        kill_now        = kill;
        mem_req_next    = mem_req_o;
        mem_we_next     = mem_we_o;
        mem_addr_next   = mem_addr_o;
        mem_wdata_next  = mem_wdata_o;
        if_rdata_next   = if_rdata_o;
        dm_rdata_next   = dm_rdata_o;
        if_done_next    = 1'b0;
        dm_done_next    = 1'b0;

        case (state)
            IDLE: begin
                kill_next = 1'b0;
                if (dm_eligible || if_eligible) begin
                    mem_req_next = 1'b1;
                    if (grant_dm) begin
                        state_next      = DM_WAIT;
                        last_grant_next = GNT_DM;
                        mem_we_next     = dm_we_i;
                        mem_addr_next   = dm_addr_i;
                        mem_wdata_next  = dm_wdata_i;
                    end else begin
                        state_next      = IF_WAIT;
                        last_grant_next = GNT_IF;
                        mem_we_next     = 1'b0;
                        mem_addr_next   = if_addr_i;
                        mem_wdata_next  = '0;
                        kill_next       = if_flush_i;
                    end
                end
            end
            IF_WAIT: begin
                kill_now  = kill | if_flush_i;
                kill_next = kill_now;
                if (mem_ack_i) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    kill_next    = 1'b0;
                    if (!kill_now) begin
                        if_rdata_next = mem_rdata_i;
                        if_done_next  = 1'b1;
                    end
                end
            end
            DM_WAIT: begin
                if (mem_ack_i) begin
                    state_next   = IDLE;
                    mem_req_next = 1'b0;
                    dm_done_next = 1'b1;
                    if (!mem_we_o) begin
                        dm_rdata_next = mem_rdata_i;
                    end
                end
            end
            default: begin
                state_next   = IDLE;
                mem_req_next = 1'b0;
                kill_next    = 1'b0;
            end
        endcase
    end

`ifdef MEM_PORT_ARBITER_PERF_EN
    mem_port_arbiter_perf_cnt #(.WIDTH(PERF_CNT_W)) u_perf_if (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (if_stall_o),
        .count_o (perf_if_stall_o)
    );

    mem_port_arbiter_perf_cnt #(.WIDTH(PERF_CNT_W)) u_perf_dm (
        .clk_i   (clk_i),
        .rst_n_i (rst_n_i),
        .inc_i   (dm_stall_o),
        .count_o (perf_dm_stall_o)
    );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Scoreboard testbench for mem_port_arbiter: a memory model checks each
// request against queued expectations, and a monitor checks every done pulse.
module tb_mem_port_arbiter;
    import mem_port_arbiter_pkg::*;

    logic        clk_i = 1'b0;
    logic        rst_n_i = 1'b0;
    logic        if_req_i, if_flush_i, dm_req_i, dm_we_i;
    logic [31:0] if_addr_i, dm_addr_i, dm_wdata_i;
    logic [31:0] if_rdata_o, dm_rdata_o, mem_addr_o, mem_wdata_o;
    logic        if_done_o, if_stall_o, dm_done_o, dm_stall_o, mem_req_o, mem_we_o;
    logic [31:0] mem_rdata_i = 32'hBAD0_BAD0;
    logic        model_ack = 1'b0;
    logic        stray_ack = 1'b0;
    logic        mem_ack_i;
`ifdef MEM_PORT_ARBITER_PERF_EN
    logic [31:0] perf_if_stall_o, perf_dm_stall_o;
`endif

    assign mem_ack_i = model_ack | stray_ack;

    typedef struct {
        logic [31:0] addr;
        logic        we;
        logic [31:0] wdata;
        int          delay;
        logic [31:0] rdata;
    } mem_exp_t;

    mem_exp_t    exp_mem[$];
    logic [31:0] exp_if[$];
    logic [31:0] exp_dm[$];
    int          n_checks = 0;
    int          n_fail = 0;

    mem_port_arbiter #(.ADDR_W(32), .DATA_W(32)) dut (
        .clk_i       (clk_i),
        .rst_n_i     (rst_n_i),
        .if_req_i    (if_req_i),
        .if_addr_i   (if_addr_i),
        .if_flush_i  (if_flush_i),
        .if_rdata_o  (if_rdata_o),
        .if_done_o   (if_done_o),
        .if_stall_o  (if_stall_o),
        .dm_req_i    (dm_req_i),
        .dm_we_i     (dm_we_i),
        .dm_addr_i   (dm_addr_i),
        .dm_wdata_i  (dm_wdata_i),
        .dm_rdata_o  (dm_rdata_o),
        .dm_done_o   (dm_done_o),
        .dm_stall_o  (dm_stall_o),
        .mem_req_o   (mem_req_o),
        .mem_we_o    (mem_we_o),
        .mem_addr_o  (mem_addr_o),
        .mem_wdata_o (mem_wdata_o),
        .mem_rdata_i (mem_rdata_i),
        .mem_ack_i   (mem_ack_i)
`ifdef MEM_PORT_ARBITER_PERF_EN
        ,
        .perf_if_stall_o (perf_if_stall_o),
        .perf_dm_stall_o (perf_dm_stall_o)
`endif
    );

    // Free-running clock.
    initial forever #5 clk_i = ~clk_i;

    // Hard time limit so the bench can never hang.
    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation time limit reached");
        $fatal(1, "[TB] watchdog expired");
    end

    function automatic mem_exp_t mk_exp(input logic [31:0] addr, input logic we,
                                        input logic [31:0] wdata, input int delay,
                                        input logic [31:0] rdata);
        mem_exp_t e;
        e.addr  = addr;
        e.we    = we;
        e.wdata = wdata;
        e.delay = delay;
        e.rdata = rdata;
        return e;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_fail++;
            $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic if_req, input logic [31:0] if_addr, input logic if_flush,
                                 input logic dm_req, input logic dm_we, input logic [31:0] dm_addr,
                                 input logic [31:0] dm_wdata);
        if_req_i   = if_req;
        if_addr_i  = if_addr;
        if_flush_i = if_flush;
        dm_req_i   = dm_req;
        dm_we_i    = dm_we;
        dm_addr_i  = dm_addr;
        dm_wdata_i = dm_wdata;
    endtask

    task automatic tick();
        @(posedge clk_i);
        #1;
    endtask

    // Counts cycles from the current one until the port's done pulse, checking latency and stall.
    task automatic run_until_done(input bit dm, input int exp_lat, input string name);
        int c = 0;
        bit seen = 1'b0;
        bit stall_ok = 1'b1;
        while (!seen && c < 50) begin
            @(negedge clk_i);
            if ((dm ? dm_done_o : if_done_o) === 1'b1) begin
                seen = 1'b1;
                checkOutput({name, " latency"}, 32'(c), 32'(exp_lat));
                checkOutput({name, " stall in done cycle"}, 32'(dm ? dm_stall_o : if_stall_o), 32'd0);
            end else if ((dm ? dm_stall_o : if_stall_o) !== 1'b1) begin
                stall_ok = 1'b0;
            end
            tick();
            c++;
        end
        if (!seen) checkOutput({name, " done timeout"}, 32'd0, 32'd1);
        checkOutput({name, " stall while pending"}, 32'(stall_ok), 32'd1);
    endtask

    // Memory model: checks each new request against the queue and holds it for its latency.
    initial begin : mem_model
        int       wait_cnt;
        bit       active;
        mem_exp_t cur;
        wait_cnt = 0;
        active   = 1'b0;
        cur      = mk_exp(32'd0, 1'b0, 32'd0, 1, 32'd0);
        forever begin
            @(negedge clk_i);
            model_ack   = 1'b0;
            mem_rdata_i = 32'hBAD0_BAD0;
            if (mem_req_o !== 1'b1) begin
                active   = 1'b0;
                wait_cnt = 0;
            end else begin
                if (!active) begin
                    active   = 1'b1;
                    wait_cnt = 0;
                    if (exp_mem.size() == 0) begin
                        checkOutput("unexpected mem_req", 32'd1, 32'd0);
                        cur = mk_exp(mem_addr_o, mem_we_o, mem_wdata_o, 1, 32'd0);
                    end else begin
                        cur = exp_mem.pop_front();
                        checkOutput("mem_addr", mem_addr_o, cur.addr);
                        checkOutput("mem_we", 32'(mem_we_o), 32'(cur.we));
                        if (cur.we) checkOutput("mem_wdata", mem_wdata_o, cur.wdata);
                    end
                end else begin
                    checkOutput("mem_addr stable", mem_addr_o, cur.addr);
                    checkOutput("mem_we stable", 32'(mem_we_o), 32'(cur.we));
                end
                wait_cnt++;
                if (wait_cnt >= cur.delay) begin
                    model_ack   = 1'b1;
                    mem_rdata_i = cur.rdata;
                    active      = 1'b0;
                end
            end
        end
    end

    // Monitor: every done pulse must match the next expected response for that port.
    initial begin : monitor
        forever begin
            @(negedge clk_i);
            if (if_done_o === 1'b1) begin
                if (exp_if.size() == 0) checkOutput("unexpected if_done", 32'd1, 32'd0);
                else checkOutput("if_rdata", if_rdata_o, exp_if.pop_front());
            end
            if (dm_done_o === 1'b1) begin
                if (exp_dm.size() == 0) checkOutput("unexpected dm_done", 32'd1, 32'd0);
                else checkOutput("dm_rdata", dm_rdata_o, exp_dm.pop_front());
            end
        end
    end

    // Directed test sequence.
    initial begin
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        rst_n_i = 1'b0;
        repeat (2) tick();
        @(negedge clk_i);
        checkOutput("reset mem_req", 32'(mem_req_o), 32'd0);
        checkOutput("reset mem_addr", mem_addr_o, 32'd0);
        checkOutput("reset if_rdata", if_rdata_o, 32'd0);
        checkOutput("reset dm_rdata", dm_rdata_o, 32'd0);
        checkOutput("reset dones", 32'({if_done_o, dm_done_o}), 32'd0);
        tick();
        rst_n_i = 1'b1;

        // Contention straight after reset: DM write wins, IF follows after the gap.
        exp_mem.push_back(mk_exp(32'h4, 1'b1, 32'hDEAD_BEEF, 1, 32'h5555_AAAA));
        exp_mem.push_back(mk_exp(32'h30, 1'b0, 32'd0, 1, 32'h1111_2222));
        exp_dm.push_back(32'd0);
        exp_if.push_back(32'h1111_2222);
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b1, 1'b1, 32'h4, 32'hDEAD_BEEF);
        run_until_done(1'b1, 2, "contention dm");
        applyStimulus(1'b1, 32'h30, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        run_until_done(1'b0, 1, "contention if");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Single fetch with ack on the first request cycle.
        exp_mem.push_back(mk_exp(32'h10, 1'b0, 32'd0, 1, 32'h2002_0005));
        exp_if.push_back(32'h2002_0005);
        applyStimulus(1'b1, 32'h10, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        run_until_done(1'b0, 2, "single fetch");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Data read with a 5-cycle ack.
        exp_mem.push_back(mk_exp(32'h8, 1'b0, 32'd0, 5, 32'hCAFE_0008));
        exp_dm.push_back(32'hCAFE_0008);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h8, 32'd0);
        run_until_done(1'b1, 6, "dm var latency");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Contention with DM granted last: IF wins this time.
        exp_mem.push_back(mk_exp(32'h50, 1'b0, 32'd0, 1, 32'h5050_5050));
        exp_mem.push_back(mk_exp(32'h60, 1'b0, 32'd0, 2, 32'h6060_6060));
        exp_if.push_back(32'h5050_5050);
        exp_dm.push_back(32'h6060_6060);
        applyStimulus(1'b1, 32'h50, 1'b0, 1'b1, 1'b0, 32'h60, 32'd0);
        run_until_done(1'b0, 2, "round robin if");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h60, 32'd0);
        run_until_done(1'b1, 2, "round robin dm");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Flush during IF_WAIT: killed fetch completes silently, redirected fetch follows.
        exp_mem.push_back(mk_exp(32'h20, 1'b0, 32'd0, 4, 32'h2020_2020));
        exp_mem.push_back(mk_exp(32'h40, 1'b0, 32'd0, 1, 32'h4040_4040));
        exp_if.push_back(32'h4040_4040);
        applyStimulus(1'b1, 32'h20, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        applyStimulus(1'b1, 32'h20, 1'b1, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        applyStimulus(1'b1, 32'h40, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        repeat (3) tick();
        @(negedge clk_i);
        checkOutput("flush suppresses if_done", 32'(if_done_o), 32'd0);
        checkOutput("flush keeps if_rdata", if_rdata_o, 32'h5050_5050);
        checkOutput("flush if_stall held", 32'(if_stall_o), 32'd1);
        tick();
        run_until_done(1'b0, 1, "refetch after flush");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();

        // Reset in the middle of a long data read, then a stray ack while idle.
        exp_mem.push_back(mk_exp(32'hC, 1'b0, 32'd0, 10, 32'h0C0C_0C0C));
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'hC, 32'd0);
        repeat (3) tick();
        rst_n_i = 1'b0;
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        @(negedge clk_i);
        checkOutput("mid-reset mem_req", 32'(mem_req_o), 32'd0);
        checkOutput("mid-reset dm_rdata", dm_rdata_o, 32'd0);
        checkOutput("mid-reset if_rdata", if_rdata_o, 32'd0);
        checkOutput("mid-reset dones", 32'({if_done_o, dm_done_o}), 32'd0);
        tick();
        rst_n_i   = 1'b1;
        stray_ack = 1'b1;
        tick();
        stray_ack = 1'b0;
        @(negedge clk_i);
        checkOutput("stray ack mem_req", 32'(mem_req_o), 32'd0);
        checkOutput("stray ack dones", 32'({if_done_o, dm_done_o}), 32'd0);
        tick();

        // Data write with a 4-cycle ack; write leaves dm_rdata at its reset value.
        exp_mem.push_back(mk_exp(32'h100, 1'b1, 32'h1234_5678, 4, 32'hFFFF_0000));
        exp_dm.push_back(32'd0);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b1, 32'h100, 32'h1234_5678);
        run_until_done(1'b1, 5, "dm write 4-cycle");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
`ifdef MEM_PORT_ARBITER_PERF_EN
        @(negedge clk_i);
        checkOutput("perf_dm_stall", perf_dm_stall_o, 32'd5);
        checkOutput("perf_if_stall", perf_if_stall_o, 32'd0);
        tick();
        dut.u_perf_dm.count = 32'hFFFF_FFFE;
        exp_mem.push_back(mk_exp(32'h104, 1'b0, 32'd0, 1, 32'h0000_0104));
        exp_dm.push_back(32'h0000_0104);
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b1, 1'b0, 32'h104, 32'd0);
        run_until_done(1'b1, 2, "dm read saturate");
        applyStimulus(1'b0, 32'd0, 1'b0, 1'b0, 1'b0, 32'd0, 32'd0);
        tick();
        @(negedge clk_i);
        checkOutput("perf_dm_stall saturated", perf_dm_stall_o, 32'hFFFF_FFFF);
        tick();
`endif

        checkOutput("leftover mem expectations", 32'(exp_mem.size()), 32'd0);
        checkOutput("leftover if expectations", 32'(exp_if.size()), 32'd0);
        checkOutput("leftover dm expectations", 32'(exp_dm.size()), 32'd0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/mem_port_arbiter.md
Name: mem_port_arbiter

Overview:
- Shares one single-ported, variable-latency memory between the pipeline's instruction-fetch (IF) port and data-memory (MEM-stage) port.
- Sequences each access with a req/ack handshake toward memory.
- Returns registered read data and drives per-port stall signals, which the pipeline ORs into its PC and pipeline-register write enables.
- Sits between the pipeline top level and the external memory model.

Parameters:
- ADDR_W, 32, address width of all ports.
- DATA_W, 32, data width of all ports.

Ports:
- clk_i  in  1  clock
- rst_n_i  in  1  synchronous active-low reset
- if_req_i  in  1  fetch request, level
- if_addr_i  in  ADDR_W  fetch address
- if_flush_i  in  1  branch/jump flush; kills the outstanding fetch
- if_rdata_o  out  DATA_W  fetched instruction, registered
- if_done_o  out  1  one-cycle pulse: if_rdata_o valid
- if_stall_o  out  1  fetch not yet complete
- dm_req_i  in  1  data request, level
- dm_we_i  in  1  1 = write, 0 = read
- dm_addr_i  in  ADDR_W  data address
- dm_wdata_i  in  DATA_W  write data
- dm_rdata_o  out  DATA_W  load data, registered
- dm_done_o  out  1  one-cycle pulse: data access complete
- dm_stall_o  out  1  data access not yet complete
- mem_req_o  out  1  memory request, registered
- mem_we_o  out  1  memory write enable
- mem_addr_o  out  ADDR_W  memory address
- mem_wdata_o  out  DATA_W  memory write data
- mem_rdata_i  in  DATA_W  memory read data, valid with mem_ack_i
- mem_ack_i  in  1  memory completion, one cycle

Behaviour:
- Clock and reset:
  - One clock domain, clk_i.
  - Reset is synchronous, active-low on rst_n_i.
  - Reset values: state=IDLE; last_grant=IF; kill=0; all outputs 0; rdata registers 0.
- States: IDLE, IF_WAIT, DM_WAIT.
- IDLE arbitration:
  - Only dm_req_i high -> DM.
  - Only if_req_i high -> IF.
  - Both high -> grant the port not in last_grant (round-robin). After reset, DM wins first.
- On grant:
  - Latch addr, we (IF forces we=0) and wdata into mem_*_o.
  - mem_req_o=1 from the next cycle.
  - Update last_grant.
- WAIT states:
  - Hold mem_req_o and all mem_*_o stable until mem_ack_i.
  - mem_ack_i may arrive in the first cycle mem_req_o is high.
- On mem_ack_i:
  - mem_req_o=0 next cycle.
  - Read: capture mem_rdata_i into the granted port's rdata register.
  - Pulse that port's done next cycle.
  - Return to IDLE.
  - A write leaves dm_rdata_o unchanged.
- Latency: request sampled in cycle 0 -> mem_req_o in cycle 1 -> ack in cycle k≥1 -> done in cycle k+1. Minimum 2 cycles.
- Back-to-back accesses have a 1-cycle IDLE gap.
- Stall outputs:
  - if_stall_o = if_req_i & ~if_done_o; dm_stall_o = dm_req_i & ~dm_done_o (combinational).
  - Requesters hold req/addr/wdata stable while stalled.
  - A req still high in the cycle after done is a new access.
- Flush:
  - if_flush_i in IDLE: no effect.
  - if_flush_i during IF_WAIT, or in the same cycle IF is granted: set kill.
  - A killed access still completes on the memory side; if_done_o is suppressed and if_rdata_o is not updated.
  - kill clears on return to IDLE.
  - if_flush_i during DM_WAIT: no effect.
- mem_ack_i in IDLE: ignored.
- Reset mid-access: mem_req_o drops at the reset edge. Memory tolerates an abandoned request.
- Unknown states: decode to IDLE.

Optional Feature:
- Macro: MEM_PORT_ARBITER_PERF_EN.
- Defined:
  - Adds outputs perf_if_stall_o[31:0] and perf_dm_stall_o[31:0].
  - Each increments every cycle its stall output is 1.
  - Saturates at 32'hFFFFFFFF; resets to 0.
- Undefined: ports and counters are absent; behaviour is otherwise identical.

Decomposition:
- Package mem_port_arbiter_pkg:
  - State enum (IDLE, IF_WAIT, DM_WAIT).
  - Grant enum (GNT_IF, GNT_DM).
  - Default ADDR_W/DATA_W constants.
- Sub-module: mem_port_arbiter_perf_cnt, a saturating counter instantiated twice, compiled only under the macro.
- Arbitration and FSM stay in the top module.

Test Plan:
- Single fetch: if_req_i=1, if_addr_i=32'h0000_0010, ack on the first mem_req_o cycle with rdata=32'h2002_0005 -> mem_addr_o=32'h10, we=0; if_done_o pulses in cycle 2; if_rdata_o=32'h2002_0005; if_stall_o high in cycles 0-1 only.
- Contention after reset: if_req_i and dm_req_i both high (dm_we_i=1, addr 32'h4, wdata 32'hDEAD_BEEF) -> DM granted first with mem_we_o=1; IF follows after the 1-cycle gap; dm_rdata_o stays 0.
- Variable latency: dm read at 32'h8 with ack delayed 5 cycles -> mem_* stable for 5 cycles; dm_done_o in cycle 6; dm_stall_o high in cycles 0-5.
- Flush: if_flush_i pulsed in the cycle after the IF grant, ack 3 cycles later -> no if_done_o; if_rdata_o unchanged; new fetch granted from IDLE.
- Reset mid-access: rst_n_i=0 during DM_WAIT -> mem_req_o=0 and all done/rdata outputs=0 next cycle; stray mem_ack_i in IDLE ignored.
- PERF_EN: one dm access with 4-cycle ack -> perf_dm_stall_o=5, perf_if_stall_o=0; preload near saturation -> holds 32'hFFFFFFFF.
